// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/MUX_2to1.sv
// Generic 2:1 multiplexer; sel_i = 0 passes in0_i, sel_i = 1 passes in1_i.
module MUX_2to1 #(
    parameter int unsigned size = 1
) (
    input  logic            sel_i,
    input  logic [size-1:0] in0_i,
    input  logic [size-1:0] in1_i,
    output logic [size-1:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the fetch port (0) and
// the data port (1); one access at a time, sequenced IDLE -> BUSY -> DONE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              sel_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned     CntW   = $clog2(MEM_LAT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_LAT);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            last_q;
    logic            sel_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic            any_req;
    logic            grant;
    logic            we_sel;

    assign any_req = req0_i | req1_i;
    // On a tie the port not granted last wins; otherwise whichever port is asking.
    assign grant   = (req0_i & req1_i) ? ~last_q : req1_i;

    MUX_2to1 #(.size(ADDR_W)) u_addr_mux (
        .sel_i (sel_q),
        .in0_i (addr0_i),
        .in1_i (addr1_i),
        .out_o (mem_addr_o)
    );

    MUX_2to1 #(.size(DATA_W)) u_wdata_mux (
        .sel_i (sel_q),
        .in0_i (wdata0_i),
        .in1_i (wdata1_i),
        .out_o (mem_wdata_o)
    );

    MUX_2to1 #(.size(1)) u_we_mux (
        .sel_i (sel_q),
        .in0_i (we0_i),
        .in1_i (we1_i),
        .out_o (we_sel)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (cnt_q == CntMax) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en_o = 1'b0;
        mem_we_o = 1'b0;
        ack0_o   = 1'b0;
        ack1_o   = 1'b0;
        unique case (state_q)
            BUSY: begin
                if (cnt_q == '0) begin
                    mem_en_o = 1'b1;
                    mem_we_o = we_sel;
                end
            end
            DONE: begin
                ack0_o = (sel_q == PORT_IF);
                ack1_o = (sel_q == PORT_DM);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            last_q   <= PORT_DM;
            sel_q    <= PORT_IF;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        sel_q  <= grant;
                        last_q <= grant;
                        cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntMax && !we_sel) begin
                        if (sel_q == PORT_DM) begin
                            rdata1_q <= mem_rdata_i;
                        end else begin
                            rdata0_q <= mem_rdata_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel_o    = sel_q;
    assign rdata0_o = rdata0_q;
    assign rdata1_o = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT = 2 and a two-stage pipelined memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, sel, mem_en, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MEM_LAT (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req0_i      (req0),
        .req1_i      (req1),
        .we0_i       (we0),
        .we1_i       (we1),
        .addr0_i     (addr0),
        .addr1_i     (addr1),
        .wdata0_i    (wdata0),
        .wdata1_i    (wdata1),
        .ack0_o      (ack0),
        .ack1_o      (ack1),
        .rdata0_o    (rdata0),
        .rdata1_o    (rdata1),
        .sel_o       (sel),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Memory: read data valid two cycles after the enable cycle, garbage otherwise.
    logic [1:0]  mv_q = 2'b00;
    logic [31:0] ma0_q = '0;
    logic [31:0] ma1_q = '0;
    always @(posedge clk) begin
        mv_q  <= {mv_q[0], mem_en & ~mem_we};
        ma0_q <= mem_addr;
        ma1_q <= ma0_q;
    end
    assign mem_rdata = !mv_q[1]        ? 32'hBAD0_BAD0 :
                       (ma1_q == 32'h10) ? 32'hDEAD_BEEF : {16'hC0DE, ma1_q[15:0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ack0", ack0, 0);
            check("rst_ack1", ack1, 0);
            check("rst_en", mem_en, 0);
            check("rst_we", mem_we, 0);
            check("rst_sel", sel, 0);
            check("rst_rdata0", rdata0, 0);
            check("rst_rdata1", rdata1, 0);
            check("rst_addr", mem_addr, 0);
            check("rst_wdata", mem_wdata, 0);
        end
        rst = 1'b0;
        step();

        // Single read on port 0
        req0 = 1'b1; addr0 = 32'h10;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) step();
            check("rd_en", mem_en, (c == 1));
            check("rd_ack0", ack0, (c == 4));
            check("rd_ack1", ack1, 0);
            if (c == 1) check("rd_addr", mem_addr, 32'h10);
            if (c == 1) check("rd_we", mem_we, 0);
        end
        check("rd_rdata0", rdata0, 32'hDEAD_BEEF);
        req0 = 1'b0;
        step();
        check("rd_ack0_drop", ack0, 0);

        // Write on port 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h5;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) step();
            check("wr_ack1", ack1, (c == 4));
            check("wr_ack0", ack0, 0);
            if (c == 1) begin
                check("wr_sel", sel, 1);
                check("wr_en", mem_en, 1);
                check("wr_we", mem_we, 1);
                check("wr_addr", mem_addr, 32'h20);
                check("wr_wdata", mem_wdata, 32'h5);
            end
            if (c == 2) check("wr_en_off", mem_en, 0);
        end
        check("wr_rdata1", rdata1, 0);
        check("wr_rdata0", rdata0, 32'hDEAD_BEEF);
        req1 = 1'b0; we1 = 1'b0;
        step();

        // Contention: both ports hold reads continuously
        req0 = 1'b1; addr0 = 32'h40;
        req1 = 1'b1; addr1 = 32'h80;
        for (int c = 0; c <= 19; c++) begin
            if (c > 0) step();
            check("ct_ack0", ack0, (c == 4 || c == 14));
            check("ct_ack1", ack1, (c == 9 || c == 19));
            check("ct_en", mem_en, (c % 5 == 1));
            if (c == 1 || c == 11) check("ct_sel0", sel, 0);
            if (c == 6 || c == 16) check("ct_sel1", sel, 1);
            if (c == 6) check("ct_addr1", mem_addr, 32'h80);
            if (c == 4) check("ct_rdata0", rdata0, 32'hC0DE_0040);
            if (c == 9) check("ct_rdata1", rdata1, 32'hC0DE_0080);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Reset in cycle 2 of a port-0 read
        req0 = 1'b1; addr0 = 32'h30;
        step();
        check("mr_en", mem_en, 1);
        step();
        rst = 1'b1;
        step();
        check("mr_en_idle", mem_en, 0);
        check("mr_ack0", ack0, 0);
        check("mr_sel", sel, 0);
        check("mr_rdata0", rdata0, 0);
        check("mr_rdata1", rdata1, 0);
        rst = 1'b0; req0 = 1'b0;
        for (int c = 4; c <= 9; c++) begin
            step();
            if (c == 5) begin
                req1 = 1'b1; addr1 = 32'h24;
            end
            check("mr_ack0_none", ack0, 0);
            check("mr_ack1", ack1, (c == 9));
            check("mr_en2", mem_en, (c == 6));
        end
        check("mr_rdata1_new", rdata1, 32'hC0DE_0024);
        check("mr_rdata0_kept", rdata0, 0);
        req1 = 1'b0;
        step();

        // Port 0 alone, back to back
        req0 = 1'b1; addr0 = 32'h50;
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) step();
            check("fr_en", mem_en, (c % 5 == 1));
            check("fr_ack0", ack0, (c % 5 == 4));
            check("fr_ack1", ack1, 0);
        end
        check("fr_rdata0", rdata0, 32'hC0DE_0050);
        req0 = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
